// File: rtl/color_scheme_ctrl.sv
// Double-buffered foreground/background colour pair; host writes land in shadow
// registers and reach the colour stage only on a vsync rising edge. Define BLINK_EN for fg/bg blink swap.
module color_scheme_ctrl #(
    parameter logic [23:0] FG_DEFAULT   = 24'hE0E0E0,
    parameter logic [23:0] BG_DEFAULT   = 24'h000066,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic        wr_sel,
    input  logic [23:0] wr_data,
    output logic        wr_ack,
    input  logic        vsync,
`ifdef BLINK_EN
    input  logic        blink,
`endif
    output logic        pending,
    output logic [23:0] foregnd,
    output logic [23:0] backgnd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    if (BLINK_FRAMES < 1) begin : g_badBlinkFrames
        $error("BLINK_FRAMES must be at least 1");
    end

    state_t      r_state;
    logic [23:0] r_fgSh;
    logic [23:0] r_bgSh;
    logic [23:0] r_fgAct;
    logic [23:0] r_bgAct;
    logic        r_vsyncQ;
    logic        r_wrAck;

    logic w_frameStart;
    logic w_capture;

    assign w_frameStart = vsync & ~r_vsyncQ;
    // A write colliding with a commit edge is held off until the controller is back in IDLE.
    assign w_capture = wr_req & ~r_wrAck & (r_state != COMMIT)
                     & ~((r_state == PEND) & w_frameStart);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_fgSh   <= FG_DEFAULT;
            r_bgSh   <= BG_DEFAULT;
            r_fgAct  <= FG_DEFAULT;
            r_bgAct  <= BG_DEFAULT;
            r_vsyncQ <= 1'b0;
            r_wrAck  <= 1'b0;
        end else begin
            r_vsyncQ <= vsync;
            r_wrAck  <= w_capture;
            if (w_capture) begin
                if (wr_sel) r_fgSh <= wr_data;
                else        r_bgSh <= wr_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_capture) r_state <= PEND;
                end
                PEND: begin
                    if (w_frameStart) begin
                        r_state <= COMMIT;
                        r_fgAct <= r_fgSh;
                        r_bgAct <= r_bgSh;
                    end
                end
                COMMIT:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_ack  = r_wrAck;
    assign pending = (r_state == PEND);

`ifdef BLINK_EN
    localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

    logic [CNT_W-1:0] r_frameCnt;
    logic             r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frameCnt <= '0;
            r_phase    <= 1'b0;
        end else if (!blink) begin
            r_frameCnt <= '0;
            r_phase    <= 1'b0;
        end else if (w_frameStart) begin
            if (r_frameCnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_frameCnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_frameCnt <= r_frameCnt + 1'b1;
            end
        end
    end

    assign foregnd = r_phase ? r_bgAct : r_fgAct;
    assign backgnd = r_phase ? r_fgAct : r_bgAct;
`else
    assign foregnd = r_fgAct;
    assign backgnd = r_bgAct;
`endif

endmodule

// File: tb/tb_color_scheme_ctrl.sv
// Directed bench for color_scheme_ctrl: reset, deferred commit, handshake pacing,
// vsync/write collision, overwrite, and (with BLINK_EN) the blink swap.
module tb_color_scheme_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wrReq;
    logic        wrSel;
    logic [23:0] wrData;
    logic        wrAck;
    logic        vsync;
    logic        pending;
    logic [23:0] foregnd;
    logic [23:0] backgnd;
`ifdef BLINK_EN
    logic        blink;
`endif

    int vectorsApplied = 0;
    int miscompares    = 0;

    color_scheme_ctrl #(
        .FG_DEFAULT  (24'hE0E0E0),
        .BG_DEFAULT  (24'h000066),
        .BLINK_FRAMES(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_req (wrReq),
        .wr_sel (wrSel),
        .wr_data(wrData),
        .wr_ack (wrAck),
        .vsync  (vsync),
`ifdef BLINK_EN
        .blink  (blink),
`endif
        .pending(pending),
        .foregnd(foregnd),
        .backgnd(backgnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then let one rising edge take them and settle 1ns past it.
    task automatic applyStimulus(input logic req, input logic sel,
                                 input logic [23:0] data, input logic vs);
        wrReq  = req;
        wrSel  = sel;
        wrData = data;
        vsync  = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [23:0] expFg,
                            input logic [23:0] expBg, input logic expAck,
                            input logic expPend);
        checkOutput({tag, ".fg"},   foregnd, expFg);
        checkOutput({tag, ".bg"},   backgnd, expBg);
        checkOutput({tag, ".ack"},  {23'd0, wrAck},   {23'd0, expAck});
        checkOutput({tag, ".pend"}, {23'd0, pending}, {23'd0, expPend});
    endtask

    initial begin
        rst_n  = 1'b0;
        wrReq  = 1'b0;
        wrSel  = 1'b0;
        wrData = 24'h0;
        vsync  = 1'b0;
`ifdef BLINK_EN
        blink  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset", 24'hE0E0E0, 24'h000066, 1'b0, 1'b0);
        #3 rst_n = 1'b1;

        // Deferred commit: two writes, outputs hold until the vsync rise.
        applyStimulus(1, 1, 24'hFF0000, 0);
        checkAll("dc.wrFg", 24'hE0E0E0, 24'h000066, 1'b1, 1'b1);
        applyStimulus(1, 0, 24'h00FF00, 0);
        checkAll("dc.gap", 24'hE0E0E0, 24'h000066, 1'b0, 1'b1);
        applyStimulus(1, 0, 24'h00FF00, 0);
        checkAll("dc.wrBg", 24'hE0E0E0, 24'h000066, 1'b1, 1'b1);
        applyStimulus(0, 0, 24'h0, 0);
        checkAll("dc.hold", 24'hE0E0E0, 24'h000066, 1'b0, 1'b1);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("dc.commit", 24'hFF0000, 24'h00FF00, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 1);
        applyStimulus(0, 0, 24'h0, 0);

        // Handshake: wr_req held 5 cycles, one ack every 2 cycles, last capture wins.
        applyStimulus(1, 1, 24'h0A0A0A, 0);
        checkOutput("hs.ack1", {23'd0, wrAck}, 24'd1);
        applyStimulus(1, 1, 24'h0B0B0B, 0);
        checkOutput("hs.ack2", {23'd0, wrAck}, 24'd0);
        applyStimulus(1, 1, 24'h0C0C0C, 0);
        checkOutput("hs.ack3", {23'd0, wrAck}, 24'd1);
        applyStimulus(1, 1, 24'h0D0D0D, 0);
        checkOutput("hs.ack4", {23'd0, wrAck}, 24'd0);
        applyStimulus(1, 1, 24'h0E0E0E, 0);
        checkOutput("hs.ack5", {23'd0, wrAck}, 24'd1);
        applyStimulus(0, 1, 24'h0, 0);
        checkAll("hs.idle", 24'hFF0000, 24'h00FF00, 1'b0, 1'b1);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("hs.commit", 24'h0E0E0E, 24'h00FF00, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 1);
        applyStimulus(0, 0, 24'h0, 0);

        // Collision: write arrives on the same edge as the vsync rise while PEND.
        applyStimulus(1, 1, 24'h654321, 0);
        checkAll("col.wr", 24'h0E0E0E, 24'h00FF00, 1'b1, 1'b1);
        applyStimulus(0, 1, 24'h0, 0);
        applyStimulus(1, 1, 24'h123456, 1);
        checkAll("col.commit", 24'h654321, 24'h00FF00, 1'b0, 1'b0);
        applyStimulus(1, 1, 24'h123456, 1);
        checkAll("col.blocked", 24'h654321, 24'h00FF00, 1'b0, 1'b0);
        applyStimulus(1, 1, 24'h123456, 1);
        checkAll("col.lateAck", 24'h654321, 24'h00FF00, 1'b1, 1'b1);
        applyStimulus(0, 1, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("col.nextFrame", 24'h123456, 24'h00FF00, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);

        // Overwrite within one frame.
        applyStimulus(1, 1, 24'h111111, 0);
        applyStimulus(0, 1, 24'h0, 0);
        applyStimulus(1, 1, 24'h222222, 0);
        checkOutput("ow.ack2", {23'd0, wrAck}, 24'd1);
        applyStimulus(0, 1, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("ow.commit", 24'h222222, 24'h00FF00, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);

        // vsync rise in IDLE changes nothing.
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("idleVs", 24'h222222, 24'h00FF00, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);

        // Writing the already-active value still pends and commits.
        applyStimulus(1, 0, 24'h00FF00, 0);
        checkAll("same.wr", 24'h222222, 24'h00FF00, 1'b1, 1'b1);
        applyStimulus(0, 0, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("same.commit", 24'h222222, 24'h00FF00, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);

        // Reset mid-write drops everything, including the shadow.
        applyStimulus(1, 1, 24'hABCDEF, 0);
        checkAll("rst.preWr", 24'h222222, 24'h00FF00, 1'b1, 1'b1);
        wrReq = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkAll("rst.mid", 24'hE0E0E0, 24'h000066, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("rst.lost", 24'hE0E0E0, 24'h000066, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);
        applyStimulus(1, 1, 24'hABCDEF, 0);
        applyStimulus(0, 1, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("rst.bgShDefault", 24'hABCDEF, 24'h000066, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);

`ifdef BLINK_EN
        // Blink with a 2-frame half period: swap state flips every 2nd vsync rise.
        blink = 1'b1;
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("bl.f1", 24'hABCDEF, 24'h000066, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("bl.f2", 24'h000066, 24'hABCDEF, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("bl.f3", 24'h000066, 24'hABCDEF, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("bl.f4", 24'hABCDEF, 24'h000066, 1'b0, 1'b0);
        applyStimulus(0, 0, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        applyStimulus(0, 0, 24'h0, 0);
        applyStimulus(0, 0, 24'h0, 1);
        checkAll("bl.f6", 24'h000066, 24'hABCDEF, 1'b0, 1'b0);
        blink = 1'b0;
        applyStimulus(0, 0, 24'h0, 0);
        checkAll("bl.off", 24'hABCDEF, 24'h000066, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/color_scheme_ctrl.md
# color_scheme_ctrl

Configuration controller for the pixel colour stage. It holds the active 24-bit foreground/background RGB pair that drives the colour mux. It accepts host colour writes through a req/ack handshake into shadow registers. Shadow values are committed to the active pair only at a frame boundary (vsync rising edge), so a colour change never tears mid-frame.

## Interface
Parameters:
- FG_DEFAULT, 24'hE0E0E0: reset foreground (light gray).
- BG_DEFAULT, 24'h000066: reset background (blue).
- BLINK_FRAMES, 30: blink half-period in frames, ≥1. Used only with BLINK_EN.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  1  host write request; held high until wr_ack.
- wr_sel  in  1  target: 1 = foreground, 0 = background.
- wr_data  in  24  RGB value {R[23:16], G[15:8], B[7:0]}.
- wr_ack  out  1  one-cycle pulse; write captured into shadow.
- vsync  in  1  vertical sync, active-high, synchronous to clk.
- blink  in  1  run-time blink enable. Present only with BLINK_EN.
- pending  out  1  shadow holds an uncommitted write.
- foregnd  out  24  active foreground to the colour stage.
- backgnd  out  24  active background to the colour stage.

## Operation
- Registers: fg_sh/bg_sh (shadow), fg_act/bg_act (active), vsync_q, wr_ack, state. All reset to defaults / 0 / IDLE.
- frame_start = vsync & ~vsync_q. vsync_q is registered every cycle.
- Write capture condition: wr_req & ~wr_ack & state != COMMIT & ~(state == PEND & frame_start).
  - On capture: the shadow selected by wr_sel <= wr_data, and wr_ack <= 1.
  - Otherwise wr_ack <= 0.
- FSM:
  - IDLE: capture -> PEND.
  - PEND: frame_start -> COMMIT, with fg_act <= fg_sh and bg_act <= bg_sh on that same edge. Otherwise a capture stays in PEND.
  - COMMIT: one cycle; writes blocked -> IDLE.
- pending = (state == PEND).
- Simultaneous frame_start and wr_req in PEND: the commit wins. The write is not acked and is captured in the first IDLE cycle after COMMIT. It is then committed at the next frame.
- Multiple writes within one frame: last value per target wins. Both targets commit together.
- frame_start in IDLE: no effect.
- Writing a value equal to the active one still goes to PEND and commits.
- Reset mid-operation (any state): everything returns to reset values immediately. Uncommitted shadow data is lost, and wr_ack drops.

## Timing
- Reset values: foregnd = FG_DEFAULT, backgnd = BG_DEFAULT, wr_ack = 0, pending = 0.
- wr_ack rises on the first clk edge at which wr_req is sampled with the capture condition true. It stays high exactly 1 cycle.
- wr_req is held until wr_ack is seen, then dropped or re-presented with new data. The minimum write spacing is 2 cycles.
- pending rises on the same edge as wr_ack (from IDLE).
- Commit: foregnd/backgnd change on the first edge at which vsync is sampled 1 after being 0 on the previous edge. pending falls on that same edge.
- Outputs come straight from flops, through at most one 2:1 mux (blink).

## Configuration
- BLINK_EN defined:
  - Adds the blink port, a frame counter of width $clog2(BLINK_FRAMES)+1, and a phase flop (both reset 0).
  - While blink = 1, each frame_start increments the counter. On reaching BLINK_FRAMES-1 the counter wraps to 0 and phase toggles.
  - While blink = 0, counter and phase clear to 0 synchronously.
  - foregnd = phase ? bg_act : fg_act; backgnd = phase ? fg_act : bg_act.
  - A commit updates the act registers without altering phase.
- BLINK_EN undefined: no blink port, counter, or phase; foregnd = fg_act, backgnd = bg_act.

## Test plan
- Reset: assert rst_n = 0 mid-write -> foregnd = E0E0E0, backgnd = 000066, wr_ack = 0, pending = 0.
- Deferred commit: write fg = FF0000, then bg = 00FF00, with no vsync -> outputs unchanged and pending = 1. On vsync rise -> foregnd = FF0000 and backgnd = 00FF00 on that edge, pending = 0.
- Handshake: hold wr_req for 5 cycles with constant data -> exactly one wr_ack pulse per 2 cycles; last value wins at commit.
- Collision: in PEND, raise wr_req (fg = 123456) on the same edge as the vsync rise -> old shadow commits, no ack that cycle, ack 2 cycles later. foregnd = 123456 only after the next vsync.
- Overwrite: write fg = 111111, then fg = 222222 in one frame -> foregnd = 222222 after vsync.
- BLINK_EN with BLINK_FRAMES = 2 and blink = 1: foregnd/backgnd swap every 2 vsync rises. Set blink = 0 -> unswapped on the next cycle.
